// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: state codes, direction codes
// and the reversal rule used when committing a buffered direction.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } flow_state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Two directions are opposite when they share an axis (bit1) but point the
  // other way along it (bit0).
  function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced button level.
// Latency: press pulses one cycle after the level is first sampled high. Backpressure: none.
// Ports: sys_clk, sys_rst (sync, active high), btn (level in), press (one-cycle pulse out).
module btn_edge (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic btn,
  output logic press
);

  logic btn_prev;

  // History resets to 1 so a button held through reset is not seen as a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      btn_prev <= 1'b1;
      press    <= 1'b0;
    end else begin
      btn_prev <= btn;
      press    <= btn & ~btn_prev;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: IDLE/INIT/PLAY/PAUSE/OVER, direction buffering, high score.
// Latency: button press acts 2 cycles after its edge; upd_tick/dir_out 1 cycle after frame_tick.
// Backpressure: none; every input is sampled each cycle.
// Ports: sys_clk, sys_rst (sync, active high); btn_start, btn_pause, dir_in, frame_tick,
//        collision, score_in from board/game logic; game_rst, upd_tick, dir_out,
//        flow_state, high_score to game logic and display.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_W    = 16,
  parameter int RST_CYCLES = 4,
  parameter int OVER_TICKS = 60
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic [1:0]         dir_in,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score_in,
  output logic               game_rst,
  output logic               upd_tick,
  output logic [1:0]         dir_out,
  output logic [2:0]         flow_state,
  output logic [SCORE_W-1:0] high_score
);

  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam int OVER_W = $clog2(OVER_TICKS + 1);

  flow_state_t       state, state_next;
  logic              start_press, pause_press;
  logic [RST_W-1:0]  rst_cnt;
  logic [OVER_W-1:0] over_cnt;
  logic [1:0]        pending;
  logic              play_tick;

  btn_edge u_start_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .btn     (btn_start),
    .press   (start_press)
  );

  btn_edge u_pause_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .btn     (btn_pause),
    .press   (pause_press)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_press) state_next = ST_INIT;
      ST_INIT:  if (rst_cnt == RST_W'(RST_CYCLES - 1)) state_next = ST_PLAY;
      // Collision is checked first so it wins over a simultaneous pause.
      ST_PLAY: begin
        if (collision)        state_next = ST_OVER;
        else if (pause_press) state_next = ST_PAUSE;
      end
      ST_PAUSE: if (pause_press || start_press) state_next = ST_PLAY;
      ST_OVER:  if (start_press && (over_cnt == '0)) state_next = ST_INIT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // An update only goes out if we are staying in PLAY, so upd_tick never
  // appears in the first PAUSE/OVER cycle.
  assign play_tick = (state == ST_PLAY) && (state_next == ST_PLAY) && frame_tick;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      game_rst   <= 1'b1;
      upd_tick   <= 1'b0;
      dir_out    <= DIR_RIGHT;
      pending    <= DIR_RIGHT;
      high_score <= '0;
      over_cnt   <= '0;
      rst_cnt    <= '0;
    end else begin
      state    <= state_next;
      // Registered from the next state so game_rst lines up with flow_state==INIT.
      game_rst <= (state_next == ST_INIT);
      upd_tick <= play_tick;

      if ((state == ST_INIT) && (state_next == ST_INIT)) rst_cnt <= rst_cnt + 1'b1;
      else                                               rst_cnt <= '0;

      case (state)
        ST_INIT: begin
          dir_out <= DIR_RIGHT;
          pending <= DIR_RIGHT;
        end
        ST_PLAY: begin
          pending <= dir_in;
          if (play_tick && !is_reversal(pending, dir_out)) dir_out <= pending;
          if (state_next == ST_OVER) begin
            if (score_in > high_score) high_score <= score_in;
            over_cnt <= OVER_W'(OVER_TICKS);
          end
        end
        ST_OVER: begin
          if (frame_tick && (over_cnt != '0)) over_cnt <= over_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign flow_state = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        btn_start, btn_pause;
  logic [1:0]  dir_in;
  logic        frame_tick, collision;
  logic [15:0] score_in;
  logic        game_rst, upd_tick;
  logic [1:0]  dir_out;
  logic [2:0]  flow_state;
  logic [15:0] high_score;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {expected upd_tick, expected dir_out}
  logic [2:0] sb_q[$];

  game_flow_ctrl #(.SCORE_W(16), .RST_CYCLES(4), .OVER_TICKS(60)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .dir_in     (dir_in),
    .frame_tick (frame_tick),
    .collision  (collision),
    .score_in   (score_in),
    .game_rst   (game_rst),
    .upd_tick   (upd_tick),
    .dir_out    (dir_out),
    .flow_state (flow_state),
    .high_score (high_score)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame_tick; expected result queued on drive, compared once the DUT responds.
  task automatic frame(input logic exp_upd, input logic [1:0] exp_dir);
    logic [2:0] e;
    sb_q.push_back({exp_upd, exp_dir});
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    e = sb_q.pop_front();
    check("upd_tick", 32'(upd_tick), 32'(e[2]));
    check("dir_out", 32'(dir_out), 32'(e[1:0]));
  endtask

  task automatic over_ticks(input int n, input logic [1:0] d);
    for (int i = 0; i < n; i++) frame(1'b0, d);
  endtask

  task automatic press(input logic is_start);
    if (is_start) btn_start = 1'b1; else btn_pause = 1'b1;
    cyc();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    cyc();
  endtask

  task automatic restart_to_play(input string tag);
    bit reached;
    press(1'b1);
    check({tag, "_init"}, 32'(flow_state), 32'd1);
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      cyc();
      if (flow_state == 3'd2) reached = 1'b1;
    end
    check({tag, "_play_reached"}, 32'(reached), 32'd1);
    check({tag, "_dir"}, 32'(dir_out), 32'd3);
  endtask

  task automatic end_game(input logic [15:0] score);
    score_in  = score;
    collision = 1'b1;
    cyc();
    collision = 1'b0;
  endtask

  initial begin
    int rst_hi, init_cyc, misalign;
    logic [2:0] first_ns;

    sys_rst = 1'b1; btn_start = 1'b1; btn_pause = 1'b0; dir_in = 2'b11;
    frame_tick = 1'b0; collision = 1'b0; score_in = '0;

    // Reset state with start held through reset
    cyc();
    check("rst_game_rst", 32'(game_rst), 32'd1);
    check("rst_state", 32'(flow_state), 32'd0);
    check("rst_upd", 32'(upd_tick), 32'd0);
    check("rst_dir", 32'(dir_out), 32'd3);
    check("rst_high", 32'(high_score), 32'd0);
    sys_rst = 1'b0;
    cyc();
    check("post_rst_game_rst", 32'(game_rst), 32'd0);
    cyc(); cyc();
    check("held_btn_no_press", 32'(flow_state), 32'd0);
    btn_start = 1'b0;
    cyc();

    // Game 1 start: INIT length and ordering
    btn_start = 1'b1;
    rst_hi = 0; init_cyc = 0; misalign = 0; first_ns = 3'd7;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) btn_start = 1'b0;
      if (game_rst) rst_hi++;
      if (flow_state == 3'd1) init_cyc++;
      if (game_rst != (flow_state == 3'd1)) misalign++;
      if (flow_state != 3'd0 && first_ns == 3'd7) first_ns = flow_state;
    end
    check("init_game_rst_cycles", 32'(rst_hi), 32'd4);
    check("init_state_cycles", 32'(init_cyc), 32'd4);
    check("init_rst_only_in_init", 32'(misalign), 32'd0);
    check("init_first_state", 32'(first_ns), 32'd1);
    check("init_then_play", 32'(flow_state), 32'd2);
    check("init_dir", 32'(dir_out), 32'd3);
    check("init_no_upd", 32'(upd_tick), 32'd0);

    // Direction buffer and reversal rejection
    dir_in = 2'b10; cyc(); frame(1'b1, 2'b11);
    cyc();
    check("upd_one_cycle", 32'(upd_tick), 32'd0);
    dir_in = 2'b00; cyc(); frame(1'b1, 2'b00);
    dir_in = 2'b01; cyc(); frame(1'b1, 2'b00);
    dir_in = 2'b10; cyc(); frame(1'b1, 2'b10);

    // Pause: no updates, direction frozen; resume on second pause press
    press(1'b0);
    check("pause_state", 32'(flow_state), 32'd3);
    dir_in = 2'b00;
    over_ticks(5, 2'b10);
    check("pause_holds", 32'(flow_state), 32'd3);
    dir_in = 2'b11;
    press(1'b0);
    check("resume_state", 32'(flow_state), 32'd2);
    cyc();
    frame(1'b1, 2'b10);

    // Game 1 ends with 10
    end_game(16'd10);
    check("g1_over", 32'(flow_state), 32'd4);
    check("g1_high", 32'(high_score), 32'd10);

    // OVER countdown: presses before 60 ticks dropped
    over_ticks(10, 2'b10);
    press(1'b1);
    check("over_10_ignored", 32'(flow_state), 32'd4);
    over_ticks(49, 2'b10);
    press(1'b1);
    check("over_59_ignored", 32'(flow_state), 32'd4);
    over_ticks(1, 2'b10);
    restart_to_play("over_60");

    // Game 2 ends with 25 over a high score of 10
    end_game(16'd25);
    check("g2_over", 32'(flow_state), 32'd4);
    check("g2_high", 32'(high_score), 32'd25);
    over_ticks(60, 2'b11);
    restart_to_play("g3");

    // Game 3 ends with 7: high score kept
    end_game(16'd7);
    check("g3_over", 32'(flow_state), 32'd4);
    check("g3_high", 32'(high_score), 32'd25);
    over_ticks(60, 2'b11);
    restart_to_play("g4");

    // Collision and pause press seen in the same cycle
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    score_in  = 16'd3;
    collision = 1'b1;
    cyc();
    collision = 1'b0;
    check("coll_wins", 32'(flow_state), 32'd4);
    check("coll_high", 32'(high_score), 32'd25);
    cyc();
    check("coll_stays_over", 32'(flow_state), 32'd4);
    over_ticks(60, 2'b11);
    restart_to_play("g5");

    // Reset in the middle of PLAY
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    check("midrst_state", 32'(flow_state), 32'd0);
    check("midrst_high", 32'(high_score), 32'd0);
    check("midrst_game_rst", 32'(game_rst), 32'd1);
    check("midrst_dir", 32'(dir_out), 32'd3);
    cyc();
    check("midrst_game_rst_low", 32'(game_rst), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
